wasm_core: RTL and testbench
============================

WASM_CORE -- requirements
Module: wasm_core

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4; code address width is MEM_DEPTH+1 bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 16; operand stack entries are 64 bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset is synchronous and active-low (0 = reset).
REQ-005 SHALL have port result  output  64  value at top of operand stack, 0 when stack empty.
REQ-006 SHALL have port result_empty  output  1  1 when operand stack holds no entries.
REQ-007 SHALL have port trap  output  4  trap code, 0 = none.
REQ-008 SHALL have port mem_addr  output  MEM_DEPTH+1  byte address of the fetch window (= pc).
REQ-009 SHALL have port mem_extra  output  4  extra bytes requested beyond the first; always 15.
REQ-010 SHALL have port mem_data  input  128  fetch window; byte at mem_addr+k in bits [127-8k:120-8k].
REQ-011 SHALL have port mem_error  input  1  1 when the requested window is out of ROM bounds.

Function
REQ-012 SHALL use a synchronous code ROM: mem_data/mem_error are valid the cycle after mem_addr is driven.
REQ-013 SHALL run FSM states FETCH -> EXEC -> FETCH ...; FETCH drives mem_addr=pc; EXEC decodes mem_data byte 0 and updates pc/stack in one cycle.
REQ-014 SHALL enter HALT on end (0x0B) with trap=0; HALT and TRAP states are terminal until reset.
REQ-015 SHALL, in EXEC with mem_error=1, enter TRAP with trap=4, stack unchanged.
REQ-016 SHALL support opcodes: 0x00 unreachable (trap=1), 0x01 nop, 0x0B end, 0x1A drop, 0x41 i32.const, 0x42 i64.const, 0x6A i32.add, 0x6B i32.sub, 0x7C i64.add, 0x7D i64.sub.
REQ-017 SHALL enter TRAP with trap=5 on any other opcode.
REQ-018 SHALL decode const immediates as signed LEB128 from bytes 1.. of the window; i32.const max 5 bytes, i64.const max 10 bytes; longer encodings trap=6.
REQ-019 SHALL sign-extend i64.const to 64 bits; i32.const stores low 32 bits sign-extended to 32, upper 32 bits zero.
REQ-020 SHALL advance pc by 1 + immediate length for consts, by 1 otherwise.
REQ-021 SHALL compute i32 add/sub modulo 2^32 (upper 32 result bits zero), i64 add/sub modulo 2^64; operand order: second-from-top op top.
REQ-022 SHALL trap=2 (underflow) when an op needs more operands than present; trap=3 (overflow) on push with STACK_DEPTH entries present; stack unchanged on trap.
REQ-023 SHALL update result/result_empty registered, reflecting stack state after each EXEC.
REQ-024 SHALL perform no type checking between i32 and i64 values.

Reset
REQ-025 SHALL, while reset=0 at a rising edge, set pc=0, state=FETCH, stack empty, result=0, result_empty=1, trap=0.
REQ-026 SHALL abort any in-progress instruction on reset, including from HALT/TRAP, and restart at pc=0 after release.
REQ-027 SHALL hold all outputs at reset values while reset=0.

Verification
REQ-028 ROM 42 2A 0B (i64.const 42; end) -> within 6 cycles after reset release result=42, result_empty=0, trap=0, halted.
REQ-029 ROM 42 7F 0B -> result=0xFFFFFFFFFFFFFFFF; ROM 41 7F 0B -> result=0x00000000FFFFFFFF.
REQ-030 ROM 41 05 41 03 6B 0B -> result=2; ROM 42 01 42 7F 7C 0B -> result=0, result_empty=0.
REQ-031 ROM 1A -> trap=2, result_empty=1; ROM 00 -> trap=1; ROM FF -> trap=5.
REQ-032 ROM of only nops running past rom_upper_bound -> trap=4; pulse reset=0 mid-run -> outputs return to reset values, program restarts.
REQ-033 STACK_DEPTH+1 consecutive i64.const -> trap=3, result holds last successfully pushed value.

Source files
------------

// File: rtl/wasm_core.sv
// wasm_core: a tiny WebAssembly-subset interpreter core.
//
// Every instruction takes two cycles. FETCH presents pc on mem_addr. The
// synchronous code ROM answers one cycle later. EXEC then decodes byte 0 of
// the 16-byte window and updates pc, the operand stack, result and trap, all
// in that one cycle. HALT (after end) and TRAP are terminal until reset.
//
// ROM timing: mem_data and mem_error are sampled only in EXEC. They belong to
// the mem_addr that was driven during the preceding FETCH cycle. The core has
// no valid/ready handshake, because the ROM always answers in exactly one
// cycle.
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-low
//   result        top of operand stack (0 when empty), registered
//   result_empty  1 when the operand stack is empty, registered
//   trap          0 none, 1 unreachable, 2 underflow, 3 overflow,
//                 4 fetch out of bounds, 5 bad opcode, 6 overlong LEB128
//   mem_addr      byte address of the fetch window (= pc)
//   mem_extra     extra bytes requested beyond the first (constant 15)
//   mem_data      fetch window, byte k at bits [127-8k:120-8k]
//   mem_error     requested window lies outside the ROM
module wasm_core #(
  parameter int MEM_DEPTH   = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [63:0]        result,
  output logic               result_empty,
  output logic [3:0]         trap,
  output logic [MEM_DEPTH:0] mem_addr,
  output logic [3:0]         mem_extra,
  input  logic [127:0]       mem_data,
  input  logic               mem_error
);

  localparam int AW  = MEM_DEPTH + 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;
  localparam logic [1:0] S_TRAP  = 2'd3;

  localparam logic [3:0] T_UNREACH = 4'd1;
  localparam logic [3:0] T_UNDER   = 4'd2;
  localparam logic [3:0] T_OVER    = 4'd3;
  localparam logic [3:0] T_BOUNDS  = 4'd4;
  localparam logic [3:0] T_OPCODE  = 4'd5;
  localparam logic [3:0] T_LEB     = 4'd6;

  // state is kept as a plain named register so checkers can bind to it.
  logic [1:0]     state;
  logic [AW-1:0]  pc;
  logic [SPW-1:0] sp;
  logic [63:0]    stack_mem [STACK_DEPTH];

  logic [1:0]     nxt_state;
  logic [AW-1:0]  nxt_pc;
  logic [SPW-1:0] nxt_sp;
  logic [3:0]     nxt_trap;
  logic [63:0]    nxt_result;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [63:0]    wr_val;

  assign mem_addr  = pc;
  assign mem_extra = 4'd15;

  // Bytes 11..15 of the window are never needed, because the longest
  // instruction is 11 bytes.
  logic unused_window;
  assign unused_window = ^mem_data[39:0];

  logic [7:0] opcode;
  assign opcode = mem_data[127:120];

  // Stack operands. An index is only meaningful when sp is deep enough, and
  // every use below is guarded by a depth check.
  logic [IW-1:0] top_idx, sec_idx, push_idx;
  logic [63:0]   top_val, sec_val;
  assign top_idx  = IW'(sp - SPW'(1));
  assign sec_idx  = IW'(sp - SPW'(2));
  assign push_idx = IW'(sp);
  assign top_val  = stack_mem[top_idx];
  assign sec_val  = stack_mem[sec_idx];

  // Signed LEB128 over window bytes 1..10. leb_raw packs the 7-bit groups.
  // leb_len is the position of the first byte with bit 7 clear. The value is
  // sign-extended from the top bit of the last group that was consumed.
  logic [69:0] leb_raw;
  logic [3:0]  leb_len;
  logic        leb_done;
  logic [63:0] leb_val;

  always_comb begin
    leb_raw  = '0;
    leb_len  = '0;
    leb_done = 1'b0;
    leb_val  = '0;
    for (int k = 0; k < 10; k++) begin
      leb_raw[7*k +: 7] = mem_data[118-8*k -: 7];
      if (!leb_done) begin
        leb_len = 4'(k + 1);
        if (!mem_data[119-8*k]) leb_done = 1'b1;
      end
    end
    for (int b = 0; b < 64; b++) begin
      leb_val[b] = (b < 7 * int'(leb_len)) ? leb_raw[b] : leb_raw[7 * int'(leb_len) - 1];
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_pc     = pc;
    nxt_sp     = sp;
    nxt_trap   = trap;
    nxt_result = result;
    wr_en      = 1'b0;
    wr_idx     = push_idx;
    wr_val     = '0;
    case (state)
      S_FETCH: nxt_state = S_EXEC;
      S_EXEC: begin
        nxt_state = S_FETCH;
        if (mem_error) begin
          nxt_state = S_TRAP;
          nxt_trap  = T_BOUNDS;
        end else begin
          case (opcode)
            8'h00: begin nxt_state = S_TRAP; nxt_trap = T_UNREACH; end
            8'h01: nxt_pc = pc + AW'(1);
            8'h0B: nxt_state = S_HALT;
            8'h1A: begin
              if (sp == '0) begin
                nxt_state = S_TRAP; nxt_trap = T_UNDER;
              end else begin
                nxt_sp     = sp - SPW'(1);
                nxt_result = (sp >= SPW'(2)) ? sec_val : 64'd0;
                nxt_pc     = pc + AW'(1);
              end
            end
            8'h41, 8'h42: begin
              if (!leb_done || (opcode == 8'h41 && leb_len > 4'd5)) begin
                nxt_state = S_TRAP; nxt_trap = T_LEB;
              end else if (sp == SPW'(STACK_DEPTH)) begin
                nxt_state = S_TRAP; nxt_trap = T_OVER;
              end else begin
                wr_en      = 1'b1;
                wr_val     = (opcode == 8'h41) ? {32'd0, leb_val[31:0]} : leb_val;
                nxt_result = wr_val;
                nxt_sp     = sp + SPW'(1);
                nxt_pc     = pc + AW'(leb_len) + AW'(1);
              end
            end
            8'h6A, 8'h6B, 8'h7C, 8'h7D: begin
              if (sp < SPW'(2)) begin
                nxt_state = S_TRAP; nxt_trap = T_UNDER;
              end else begin
                case (opcode)
                  8'h6A:   wr_val = {32'd0, sec_val[31:0] + top_val[31:0]};
                  8'h6B:   wr_val = {32'd0, sec_val[31:0] - top_val[31:0]};
                  8'h7C:   wr_val = sec_val + top_val;
                  default: wr_val = sec_val - top_val;
                endcase
                // Result replaces the second-from-top entry.
                wr_en      = 1'b1;
                wr_idx     = sec_idx;
                nxt_result = wr_val;
                nxt_sp     = sp - SPW'(1);
                nxt_pc     = pc + AW'(1);
              end
            end
            default: begin nxt_state = S_TRAP; nxt_trap = T_OPCODE; end
          endcase
        end
      end
      default: ;  // HALT and TRAP hold until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_FETCH;
      pc           <= '0;
      sp           <= '0;
      result       <= '0;
      result_empty <= 1'b1;
      trap         <= '0;
    end else begin
      state        <= nxt_state;
      pc           <= nxt_pc;
      sp           <= nxt_sp;
      result       <= nxt_result;
      result_empty <= (nxt_sp == '0);
      trap         <= nxt_trap;
    end
  end

  // Stack storage needs no reset. sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (reset && wr_en) stack_mem[wr_idx] <= wr_val;
  end

endmodule

// File: tb/tb_wasm_core.sv
// Bench for wasm_core: directed programs plus random programs. Each is
// checked per instruction and at the end against a byte-level interpreter.
module tb_wasm_core;

  localparam int MD        = 6;
  localparam int SD        = 16;
  localparam int ROM_BYTES = 1 << (MD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   result;
  logic          result_empty;
  logic [3:0]    trap;
  logic [MD:0]   mem_addr;
  logic [3:0]    mem_extra;
  logic [127:0]  mem_data;
  logic          mem_error;

  logic [7:0]    rom [ROM_BYTES];
  logic [7:0]    prog [$];
  logic [63:0]   exp_q [$];
  int            n_checks = 0;
  int            n_pass = 0;

  // clock / reset
  always #5 clk = ~clk;

  wasm_core #(.MEM_DEPTH(MD), .STACK_DEPTH(SD)) dut (
    .clk(clk), .reset(reset), .result(result), .result_empty(result_empty),
    .trap(trap), .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  // Synchronous ROM: the window for mem_addr appears one cycle later.
  always @(posedge clk) begin
    mem_error <= (int'(mem_addr) + 16 > ROM_BYTES);
    for (int k = 0; k < 16; k++)
      mem_data[127-8*k -: 8] <= rom[(int'(mem_addr) + k) % ROM_BYTES];
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Reference interpreter working directly on the ROM bytes.
  task automatic model_run(output int steps, output logic [63:0] f_res,
                           output logic f_empty, output logic [3:0] f_trap);
    logic [63:0] stk [$];
    logic [63:0] a, b, val;
    logic [7:0]  op, by;
    int pc, shift, len, maxb;
    bit done, ok;
    pc = 0; steps = 0; f_trap = 0; done = 0;
    exp_q.delete();
    while (!done) begin
      steps++;
      if (pc + 16 > ROM_BYTES) begin
        f_trap = 4; done = 1;
      end else begin
        op = rom[pc];
        case (op)
          8'h00: begin f_trap = 1; done = 1; end
          8'h01: pc += 1;
          8'h0B: done = 1;
          8'h1A: if (stk.size() < 1) begin f_trap = 2; done = 1; end
                 else begin void'(stk.pop_back()); pc += 1; end
          8'h41, 8'h42: begin
            maxb = (op == 8'h41) ? 5 : 10;
            val = 0; shift = 0; len = 0; ok = 0;
            for (int k = 1; k <= maxb; k++) begin
              by = rom[(pc + k) % ROM_BYTES];
              if (shift < 64) val |= {57'd0, by[6:0]} << shift;
              shift += 7; len = k;
              if (!by[7]) begin
                ok = 1;
                if (by[6] && shift < 64) val |= ~64'd0 << shift;
                break;
              end
            end
            if (!ok) begin f_trap = 6; done = 1; end
            else if (stk.size() == SD) begin f_trap = 3; done = 1; end
            else begin
              stk.push_back((op == 8'h41) ? {32'd0, val[31:0]} : val);
              pc += 1 + len;
            end
          end
          8'h6A, 8'h6B, 8'h7C, 8'h7D: begin
            if (stk.size() < 2) begin f_trap = 2; done = 1; end
            else begin
              b = stk.pop_back(); a = stk.pop_back();
              case (op)
                8'h6A:   val = (a + b) & 64'hFFFF_FFFF;
                8'h6B:   val = (a - b) & 64'hFFFF_FFFF;
                8'h7C:   val = a + b;
                default: val = a - b;
              endcase
              stk.push_back(val);
              pc += 1;
            end
          end
          default: begin f_trap = 5; done = 1; end
        endcase
      end
      exp_q.push_back(stk.size() > 0 ? stk[$] : 64'd0);
    end
    f_res = stk.size() > 0 ? stk[$] : 64'd0;
    f_empty = (stk.size() == 0);
  endtask

  task automatic check_reset_vals(input string name);
    check_eq({name, ".rst_result"}, result, 64'd0);
    check_eq({name, ".rst_empty"}, {63'd0, result_empty}, 64'd1);
    check_eq({name, ".rst_trap"}, {60'd0, trap}, 64'd0);
    check_eq({name, ".rst_addr"}, {{(63-MD){1'b0}}, mem_addr}, 64'd0);
    check_eq({name, ".extra"}, {60'd0, mem_extra}, 64'd15);
  endtask

  // driver: load prog, reset, optionally run a while and reset again, then
  // run to completion checking result after every instruction.
  task automatic run_prog(input string name, input logic [7:0] fill, input int pre_cycles);
    int steps;
    logic [63:0] f_res, e;
    logic f_empty;
    logic [3:0] f_trap;
    for (int i = 0; i < ROM_BYTES; i++) rom[i] = fill;
    foreach (prog[i]) rom[i] = prog[i];
    @(negedge clk); reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals(name);
    if (pre_cycles > 0) begin
      reset = 1'b1;
      repeat (pre_cycles) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals({name, ".mid"});
    end
    model_run(steps, f_res, f_empty, f_trap);
    reset = 1'b1;
    for (int i = 0; i < steps; i++) begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("%s.step%0d", name, i), result, e);
    end
    repeat (6) @(negedge clk);
    check_eq({name, ".result"}, result, f_res);
    check_eq({name, ".empty"}, {63'd0, result_empty}, {63'd0, f_empty});
    check_eq({name, ".trap"}, {60'd0, trap}, {60'd0, f_trap});
  endtask

  task automatic set_prog(input logic [7:0] bytes [$]);
    prog = bytes;
  endtask

  task automatic gen_random_prog();
    int target, sel, len;
    logic [7:0] bad [3];
    bad[0] = 8'hFF; bad[1] = 8'h10; bad[2] = 8'h20;
    prog.delete();
    target = $urandom_range(10, 90);
    for (int i = 0; i < 3; i++) begin
      prog.push_back(8'h42); prog.push_back(8'($urandom_range(0, 127)));
    end
    while (prog.size() < target) begin
      sel = $urandom_range(0, 19);
      if (sel < 8) begin
        prog.push_back(sel < 4 ? 8'h41 : 8'h42);
        len = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 11) : $urandom_range(1, 3);
        for (int j = 0; j < len - 1; j++) prog.push_back(8'h80 | 8'($urandom_range(0, 127)));
        prog.push_back(8'($urandom_range(0, 127)));
      end else if (sel < 10) prog.push_back(8'h01);
      else if (sel < 11) prog.push_back(8'h1A);
      else if (sel < 13) prog.push_back(8'h6A);
      else if (sel < 15) prog.push_back(8'h6B);
      else if (sel < 17) prog.push_back(8'h7C);
      else if (sel < 19) prog.push_back(8'h7D);
      else if ($urandom_range(0, 3) == 0) prog.push_back(bad[$urandom_range(0, 2)]);
    end
    prog.push_back(8'h0B);
  endtask

  initial begin
    set_prog('{8'h42, 8'h2A, 8'h0B});                          run_prog("i64c42", 8'h00, 0);
    set_prog('{8'h42, 8'h7F, 8'h0B});                          run_prog("i64neg1", 8'h00, 0);
    set_prog('{8'h41, 8'h7F, 8'h0B});                          run_prog("i32neg1", 8'h00, 0);
    set_prog('{8'h41, 8'h05, 8'h41, 8'h03, 8'h6B, 8'h0B});     run_prog("i32sub", 8'h00, 0);
    set_prog('{8'h42, 8'h01, 8'h42, 8'h7F, 8'h7C, 8'h0B});     run_prog("i64add0", 8'h00, 0);
    set_prog('{8'h1A});                                        run_prog("underflow", 8'h00, 0);
    set_prog('{8'h00});                                        run_prog("unreach", 8'h00, 0);
    set_prog('{8'hFF});                                        run_prog("badop", 8'h00, 0);
    set_prog('{8'h41, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h0B});
    run_prog("i32long", 8'h00, 0);
    set_prog('{8'h42, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h0B});
    run_prog("i64max10", 8'h00, 0);
    set_prog('{8'h41, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h41, 8'h01, 8'h6A, 8'h0B});
    run_prog("i32wrap", 8'h00, 0);
    prog.delete();                                             run_prog("nops", 8'h01, 0);
    set_prog('{8'h42, 8'h2A, 8'h0B});                          run_prog("midreset", 8'h01, 9);
    prog.delete();
    for (int k = 1; k <= SD + 1; k++) begin prog.push_back(8'h42); prog.push_back(8'(k)); end
    prog.push_back(8'h0B);
    run_prog("overflow", 8'h00, 0);
    for (int r = 0; r < 30; r++) begin
      gen_random_prog();
      run_prog($sformatf("rand%0d", r), 8'h00, (r % 5 == 0) ? $urandom_range(3, 20) : 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
